mpu6050_init_seq: RTL and testbench



---
 rtl/mpu6050_init_seq.sv | 257 +++++++++++++++++++++++++
 tb/tb_mpu6050_init_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu6050_init_seq.sv
// MPU6050 power-up sequencer: walks a register-write table through an IIC master,
// waits after the device reset write, retries timed-out transactions, flags done/error.
// Ports: clk50M/reset (async active-low), start pulse; IIC request side iic_en, write,
//        read, address, write_data; IIC response side read_data, done; status busy,
//        init_done, init_err, step.
// Option: define MPU_ID_CHECK_EN to insert a WHO_AM_I (0x75) read check after the reset wait.
module mpu6050_init_seq #(
    parameter int                   N_REGS       = 12,
    parameter logic [16*N_REGS-1:0] INIT_TABLE   = {16'h1913, 16'h6B01, 16'h3780,
                                                    16'h2300, 16'h6A00, 16'h3800,
                                                    16'h6C00, 16'h1A04, 16'h1C00,
                                                    16'h1B18, 16'h6B00, 16'h6B80},
    parameter int                   RST_WAIT_CYC = 5000000,
    parameter int                   TIMEOUT_CYC  = 1000000,
    parameter int                   MAX_RETRY    = 3,
    parameter logic [7:0]           DEV_ID       = 8'h68
) (
    input  logic       clk50M,
    input  logic       reset,
    input  logic       start,
    output logic       iic_en,
    output logic       write,
    output logic       read,
    output logic [7:0] address,
    output logic [7:0] write_data,
    input  logic [7:0] read_data,
    input  logic       done,
    output logic       busy,
    output logic       init_done,
    output logic       init_err,
    output logic [4:0] step
);

    localparam int RW_W = $clog2(RST_WAIT_CYC + 1);
    localparam int TM_W = $clog2(TIMEOUT_CYC + 1);
    localparam int RT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [RW_W-1:0] RW_LAST   = RW_W'(RST_WAIT_CYC - 1);
    localparam logic [TM_W-1:0] TM_LAST   = TM_W'(TIMEOUT_CYC - 1);
    localparam logic [RT_W-1:0] RT_MAX    = RT_W'(MAX_RETRY);
    localparam logic [4:0]      LAST_STEP = 5'(N_REGS - 1);

    typedef enum logic [3:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP,
        RST_WAIT,
`ifdef MPU_ID_CHECK_EN
        ID_ISSUE,
        ID_WAIT,
`endif
        DONE,
        ERR
    } state_t;

    state_t          r_state;
    logic            r_iic_en;
    logic            r_write;
    logic [7:0]      r_address;
    logic [7:0]      r_write_data;
    logic            r_busy;
    logic            r_init_done;
    logic            r_init_err;
    logic [4:0]      r_step;
    logic            r_done_q;
    logic            r_done_q2;
    logic            r_gap;
    logic            r_reissue;
    logic [RW_W-1:0] r_wait;
    logic [TM_W-1:0] r_tmo;
    logic [RT_W-1:0] r_retry;
    logic [15:0]     w_entry;
    logic            w_done_rise;

`ifdef MPU_ID_CHECK_EN
    logic            r_read;
    logic            r_id_phase;
    logic [7:0]      r_rd_samp;
    assign read = r_read;
`else
    logic            w_unused;
    assign w_unused = ^{read_data, DEV_ID};
    assign read     = 1'b0;
`endif

    assign iic_en      = r_iic_en;
    assign write       = r_write;
    assign address     = r_address;
    assign write_data  = r_write_data;
    assign busy        = r_busy;
    assign init_done   = r_init_done;
    assign init_err    = r_init_err;
    assign step        = r_step;
    assign w_done_rise = r_done_q & ~r_done_q2;

    always_comb begin
        w_entry = '0;
        for (int i = 0; i < N_REGS; i++)
            if (r_step == 5'(i))
                w_entry = INIT_TABLE[16*i +: 16];
    end

    always_ff @(posedge clk50M or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_iic_en     <= 1'b0;
            r_write      <= 1'b0;
            r_address    <= 8'h00;
            r_write_data <= 8'h00;
            r_busy       <= 1'b0;
            r_init_done  <= 1'b0;
            r_init_err   <= 1'b0;
            r_step       <= 5'd0;
            r_done_q     <= 1'b0;
            r_done_q2    <= 1'b0;
            r_gap        <= 1'b0;
            r_reissue    <= 1'b0;
            r_wait       <= '0;
            r_tmo        <= '0;
            r_retry      <= '0;
`ifdef MPU_ID_CHECK_EN
            r_read       <= 1'b0;
            r_id_phase   <= 1'b0;
            r_rd_samp    <= 8'h00;
`endif
        end else begin
            r_done_q  <= done;
            r_done_q2 <= r_done_q;
`ifdef MPU_ID_CHECK_EN
            // capture the result on the raw rise, when the master guarantees it
            if (done && !r_done_q)
                r_rd_samp <= read_data;
`endif
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_step      <= 5'd0;
                        r_init_done <= 1'b0;
                        r_init_err  <= 1'b0;
                        r_retry     <= '0;
                        r_reissue   <= 1'b0;
                        r_busy      <= 1'b1;
`ifdef MPU_ID_CHECK_EN
                        r_id_phase  <= 1'b0;
`endif
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_address    <= w_entry[15:8];
                    r_write_data <= w_entry[7:0];
                    r_write      <= 1'b1;
`ifdef MPU_ID_CHECK_EN
                    r_read       <= 1'b0;
`endif
                    r_iic_en     <= 1'b1;
                    r_tmo        <= '0;
                    r_state      <= WAIT_DONE;
                end
`ifdef MPU_ID_CHECK_EN
                ID_ISSUE: begin
                    r_address    <= 8'h75;
                    r_write_data <= 8'h00;
                    r_write      <= 1'b0;
                    r_read       <= 1'b1;
                    r_iic_en     <= 1'b1;
                    r_tmo        <= '0;
                    r_state      <= ID_WAIT;
                end
                ID_WAIT,
`endif
                WAIT_DONE: begin
                    if (w_done_rise) begin
                        r_iic_en  <= 1'b0;
                        r_retry   <= '0;
                        r_reissue <= 1'b0;
                        r_gap     <= 1'b0;
                        r_state   <= GAP;
                    end else if (r_tmo == TM_LAST) begin
                        r_iic_en <= 1'b0;
                        if (r_retry == RT_MAX) begin
                            r_state <= ERR;
                        end else begin
                            r_retry   <= r_retry + 1'b1;
                            r_reissue <= 1'b1;
                            r_gap     <= 1'b0;
                            r_state   <= GAP;
                        end
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                GAP: begin
                    if (!r_gap) begin
                        r_gap <= 1'b1;
                    end else begin
                        r_gap <= 1'b0;
                        if (r_reissue) begin
                            r_reissue <= 1'b0;
`ifdef MPU_ID_CHECK_EN
                            r_state   <= r_id_phase ? ID_ISSUE : ISSUE;
`else
                            r_state   <= ISSUE;
`endif
                        end
`ifdef MPU_ID_CHECK_EN
                        else if (r_id_phase) begin
                            r_id_phase <= 1'b0;
                            if (r_rd_samp == DEV_ID) begin
                                r_step  <= 5'd1;
                                r_state <= ISSUE;
                            end else begin
                                r_state <= ERR;
                            end
                        end
`endif
                        else if (r_step == 5'd0) begin
                            r_wait  <= '0;
                            r_state <= RST_WAIT;
                        end else if (r_step == LAST_STEP) begin
                            r_state <= DONE;
                        end else begin
                            r_step  <= r_step + 5'd1;
                            r_state <= ISSUE;
                        end
                    end
                end
                RST_WAIT: begin
                    if (r_wait == RW_LAST) begin
`ifdef MPU_ID_CHECK_EN
                        r_id_phase <= 1'b1;
                        r_state    <= ID_ISSUE;
`else
                        r_step     <= 5'd1;
                        r_state    <= ISSUE;
`endif
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                DONE: begin
                    r_init_done <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                ERR: begin
                    r_init_err <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu6050_init_seq.sv
// Randomized bench for mpu6050_init_seq: IIC master model plus a transaction-list
// reference model built from the init table; reports one summary line.
module tb_mpu6050_init_seq;

    localparam int NR  = 12;
    localparam int RWC = 10;
    localparam int TMO = 50;
    localparam int MR  = 3;

    localparam logic [15:0] TBL [NR] = '{
        16'h6B80, 16'h6B00, 16'h1B18, 16'h1C00, 16'h1A04, 16'h6C00,
        16'h3800, 16'h6A00, 16'h2300, 16'h3780, 16'h6B01, 16'h1913
    };

    logic       clk50M;
    logic       reset;
    logic       start;
    logic       iic_en;
    logic       write;
    logic       read;
    logic [7:0] address;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       done;
    logic       busy;
    logic       init_done;
    logic       init_err;
    logic [4:0] step;

    mpu6050_init_seq #(
        .RST_WAIT_CYC (RWC),
        .TIMEOUT_CYC  (TMO),
        .MAX_RETRY    (MR)
    ) u_dut (
        .clk50M     (clk50M),
        .reset      (reset),
        .start      (start),
        .iic_en     (iic_en),
        .write      (write),
        .read       (read),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .done       (done),
        .busy       (busy),
        .init_done  (init_done),
        .init_err   (init_err),
        .step       (step)
    );

    initial begin
        clk50M = 1'b0;
        forever #10 clk50M = ~clk50M;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // master model configuration
    int         lat_cfg  = 20;
    bit         lat_rand = 0;
    bit         spur_en  = 0;
    int         mute_idx = -1;
    logic [7:0] id_val   = 8'h68;

    bit         m_active, m_fired, m_mute;
    int         m_cnt, m_lat, spur_cd;

    initial begin
        done = 1'b0;
        read_data = 8'h00;
        m_active = 0; m_fired = 0; m_mute = 0; m_cnt = 0; m_lat = 0; spur_cd = 0;
        forever begin
            @(posedge clk50M);
            #1;
            done = 1'b0;
            if (!reset) begin
                m_active = 0;
                m_fired  = 0;
                spur_cd  = 0;
            end else begin
                if (spur_cd > 0) begin
                    spur_cd--;
                    if (spur_cd == 0) done = 1'b1;
                end
                if (!iic_en) begin
                    m_active = 0;
                    m_fired  = 0;
                end else if (!m_active) begin
                    m_active = 1;
                    m_fired  = 0;
                    m_cnt    = 0;
                    m_lat    = lat_rand ? int'($urandom_range(2, 40)) : lat_cfg;
                    m_mute   = (mute_idx >= 0) && write &&
                               ({address, write_data} == TBL[mute_idx]);
                end else if (!m_fired && !m_mute) begin
                    m_cnt++;
                    if (m_cnt >= m_lat) begin
                        done      = 1'b1;
                        read_data = read ? id_val : 8'($urandom);
                        m_fired   = 1;
                        if (spur_en) spur_cd = 2;
                    end
                end
            end
        end
    end

    // transaction monitor
    logic [17:0] obs_q [$];
    int          rise_q [$];
    int          fall_q [$];
    int          cyc = 0;
    int          unstable = 0;
    logic        mon_prev = 1'b0;
    logic [17:0] mon_last = '0;

    always @(negedge clk50M) begin
        cyc++;
        if (iic_en && !mon_prev) begin
            obs_q.push_back({read, write, address, read ? 8'h00 : write_data});
            rise_q.push_back(cyc);
            mon_last = {read, write, address, write_data};
        end else if (iic_en && mon_prev &&
                     ({read, write, address, write_data} != mon_last)) begin
            unstable++;
        end
        if (!iic_en && mon_prev) fall_q.push_back(cyc);
        mon_prev = iic_en;
    end

    // reference model: the bus transactions a run must produce
    logic [17:0] exp_q [$];
    bit          exp_done, exp_err;
    int          exp_step;

    function automatic logic [17:0] wr_key(input int i);
        return {2'b01, TBL[i]};
    endfunction

    function automatic void build_exp(input int mute, input bit id_ok);
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_step = 0;
        exp_q.push_back(wr_key(0));
`ifdef MPU_ID_CHECK_EN
        exp_q.push_back({2'b10, 8'h75, 8'h00});
        if (!id_ok) begin
            exp_err = 1;
            return;
        end
`endif
        for (int i = 1; i < NR; i++) begin
            if (i == mute) begin
                for (int k = 0; k <= MR; k++) exp_q.push_back(wr_key(i));
                exp_err  = 1;
                exp_step = i;
                return;
            end
            exp_q.push_back(wr_key(i));
        end
        exp_done = 1;
        exp_step = NR - 1;
    endfunction

    task automatic run_seq(input int mute, input bit id_ok, input bit poke,
                           input string nm);
        int ob, fb, ub;
        bit fin;
        build_exp(mute, id_ok);
        mute_idx = mute;
        id_val   = id_ok ? 8'h68 : 8'h70;
        ob = obs_q.size();
        fb = fall_q.size();
        ub = unstable;
        @(negedge clk50M) start = 1'b1;
        @(negedge clk50M) start = 1'b0;
        fin = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk50M);
            if (!busy) begin
                fin = 1;
                break;
            end
            start = poke && ($urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        chk({nm, "_finish"}, 32'(fin), 32'd1);
        chk({nm, "_ntxn"}, obs_q.size() - ob, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (ob + i < obs_q.size())
                chk($sformatf("%s_txn%0d", nm, i), 32'(obs_q[ob + i]), 32'(exp_q[i]));
            else
                chk($sformatf("%s_txn%0d", nm, i), 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
        chk({nm, "_init_done"}, 32'(init_done), 32'(exp_done));
        chk({nm, "_init_err"}, 32'(init_err), 32'(exp_err));
        chk({nm, "_step"}, 32'(step), 32'(exp_step));
        chk({nm, "_iic_en"}, 32'(iic_en), 32'd0);
        chk({nm, "_stable"}, unstable - ub, 0);
        // reset-wait spacing between entry 0 and the next transaction
        if (fall_q.size() > fb && obs_q.size() > ob + 1)
            chk({nm, "_rst_wait"}, 32'(rise_q[ob + 1] - fall_q[fb] >= RWC + 2), 32'd1);
    endtask

    initial begin
        int base, idx, got;
        bit hit;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk50M);
        chk("reset_outputs",
            {iic_en, write, read, address, write_data, busy, init_done, init_err, step},
            32'd0);
        @(negedge clk50M) reset = 1'b1;
        repeat (3) @(negedge clk50M);
        chk("idle_busy", 32'(busy), 32'd0);

        lat_cfg = 20; lat_rand = 0; spur_en = 0;
        run_seq(-1, 1, 0, "basic");

`ifdef MPU_ID_CHECK_EN
        lat_rand = 1;
        run_seq(-1, 0, 0, "id_bad");
        run_seq(-1, 1, 0, "id_ok");
`endif

        lat_rand = 1;
        run_seq(4, 1, 0, "timeout");

        lat_rand = 1; spur_en = 1;
        run_seq(-1, 1, 1, "busy_start");
        spur_en = 0;

        for (int r = 0; r < 2; r++)
            run_seq(-1, 1, 0, $sformatf("rand%0d", r));

        // reset in the middle of entry 6
        lat_rand = 0; lat_cfg = 20; mute_idx = -1;
`ifdef MPU_ID_CHECK_EN
        idx = 7;
`else
        idx = 6;
`endif
        base = obs_q.size();
        @(negedge clk50M) start = 1'b1;
        @(negedge clk50M) start = 1'b0;
        hit = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk50M);
            if (obs_q.size() - base == idx + 1 && iic_en) begin
                hit = 1;
                break;
            end
        end
        chk("midrst_reach", 32'(hit), 32'd1);
        repeat (5) @(negedge clk50M);
        chk("midrst_step", 32'(step), 32'd6);
        if (obs_q.size() > base + idx)
            chk("midrst_txn", 32'(obs_q[base + idx]), 32'(wr_key(6)));
        #3 reset = 1'b0;
        #1;
        chk("midrst_iic_en", 32'(iic_en), 32'd0);
        chk("midrst_outputs",
            {iic_en, write, read, address, write_data, busy, init_done, init_err, step},
            32'd0);
        @(negedge clk50M) reset = 1'b1;
        got = obs_q.size();
        repeat (30) @(negedge clk50M);
        chk("midrst_no_resume", obs_q.size() - got, 0);
        chk("midrst_idle", 32'(busy), 32'd0);
        run_seq(-1, 1, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
